binary_to_bcd: RTL
==================

BINARY_TO_BCD -- requirements
Module: binary_to_bcd

Interface
REQ-001 Parameter N_BITS, default 13: width of the binary input.
REQ-002 Parameter N_DIGITS, default 4: number of BCD output digits; SHALL satisfy 10^N_DIGITS > 2^N_BITS - 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  conversion request, sampled only in IDLE.
REQ-006 bin_in  input  N_BITS  unsigned binary value, captured on accepted start.
REQ-007 ready  output  1  high while in IDLE.
REQ-008 done  output  1  one-cycle pulse marking a valid result.
REQ-009 bcd_out  output  N_DIGITS x 4 (unpacked array, [0] = units)  BCD result digits.

Function
REQ-010 Conversion SHALL use shift-and-add-3 (double dabble), one bit per clock, MSB first.
REQ-011 FSM states SHALL be IDLE, OP and DONE.
REQ-012 IDLE with start=1: capture bin_in into the shift register, clear the digit registers, load the counter with N_BITS, and go to OP.
REQ-013 IDLE with start=0: hold all registers.
REQ-014 OP, each cycle: every digit > 4 gets +3, then {digits, shift register} shifts left one bit, and the counter decrements.
REQ-015 OP SHALL go to DONE on the edge that performs the N_BITS-th shift.
REQ-016 DONE SHALL assert done for exactly one cycle, then return to IDLE unconditionally.
REQ-017 Latency: with start accepted at edge 0, done SHALL be high in the cycle following edge N_BITS, and ready SHALL return high after edge N_BITS+1.
REQ-018 bcd_out SHALL be driven from the digit registers, valid from the done cycle, and held until the next accepted start.
REQ-019 bcd_out SHALL NOT be valid while in OP.
REQ-020 start in OP or DONE SHALL be ignored; it is not queued.
REQ-021 Changes on bin_in after capture SHALL NOT affect the conversion in progress.
REQ-022 Digit adjust SHALL be 4-bit modulo; with a legal N_DIGITS no digit ever exceeds 9 after the shift.
REQ-023 Counter width SHALL be clog2(N_BITS+1).

Reset
REQ-024 reset_n low SHALL force IDLE, clear the shift register, the counter and all digits, hold done=0, and drive ready=1.
REQ-025 Reset asserted mid-conversion SHALL abort the conversion; no done pulse is produced, and bcd_out reads all zeros.
REQ-026 After reset release, the first start SHALL be accepted on the next rising edge.

Structure
REQ-027 Package bin2bcd_pkg SHALL hold the state enum typedef (IDLE, OP, DONE), the digit width constant 4, and the adjust threshold constant 4.
REQ-028 Sub-module bcd_digit_adj (combinational: 4-bit in, output = in > 4 ? in + 3 : in) SHALL be instantiated once per digit via generate.
REQ-029 The top level SHALL contain the FSM, counter, shift register and digit registers only.

Verification
REQ-030 bin_in=0, start pulse -> done in cycle 14, bcd_out={0,0,0,0}, ready high at cycle 15.
REQ-031 bin_in=8191 -> bcd_out digits [3..0]=8,1,9,1 at done.
REQ-032 bin_in=1234, then bin_in changed to 5 during OP and start re-pulsed at cycle 5 -> result 1,2,3,4; single done pulse; no second conversion.
REQ-033 Back-to-back: start held high continuously with bin_in=99 then 4095 -> conversions accepted only in IDLE; results 0,0,9,9 then 4,0,9,5; done pulses 15 cycles apart.
REQ-034 reset_n pulsed low at cycle 6 of a conversion of 4321 -> done never asserted, bcd_out=0, ready=1; a fresh start of 4321 then yields 4,3,2,1.
REQ-035 Exhaustive sweep 0..8191 -> each result matches the reference model, with exactly one done per start.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package bin2bcd_pkg;
    localparam int DIGIT_W    = 4;
    localparam int ADJ_THRESH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to any digit above the threshold
// so the following left shift carries correctly into the next decade.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);
    // 4-bit wrap is intentional; legal digits never reach the wrap point.
    assign o_digit = (i_digit > DIGIT_W'(ADJ_THRESH)) ? i_digit + DIGIT_W'(3) : i_digit;
endmodule

// File: rtl/binary_to_bcd.sv
// Sequential binary-to-BCD converter: shift-and-add-3, one bit per clock,
// MSB first, with a one-cycle done pulse and registered ready.
module binary_to_bcd
    import bin2bcd_pkg::*;
#(
    parameter int N_BITS   = 13,
    parameter int N_DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [N_BITS-1:0]   bin_in,
    output logic                ready,
    output logic                done,
    output logic [DIGIT_W-1:0]  bcd_out [N_DIGITS]
);
    localparam int CNT_W = $clog2(N_BITS + 1);

    state_t                              r_state;
    logic [N_BITS-1:0]                   r_shift;
    logic [CNT_W-1:0]                    r_cnt;
    logic [N_DIGITS-1:0][DIGIT_W-1:0]    r_digits;
    logic                                r_ready;
    logic                                r_done;
    logic [N_DIGITS-1:0][DIGIT_W-1:0]    w_adj;
    logic [N_DIGITS-1:0][DIGIT_W-1:0]    w_next;

    // Each digit is adjusted, then the whole {digits, shift} chain moves left.
    for (genvar g = 0; g < N_DIGITS; g++) begin : g_dig
        bcd_digit_adj u_adj (
            .i_digit (r_digits[g]),
            .o_digit (w_adj[g])
        );
        if (g == 0) begin : g_lsd
            assign w_next[g] = {w_adj[g][DIGIT_W-2:0], r_shift[N_BITS-1]};
        end else begin : g_upper
            assign w_next[g] = {w_adj[g][DIGIT_W-2:0], w_adj[g-1][DIGIT_W-1]};
        end
        assign bcd_out[g] = r_digits[g];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_digits <= '0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_shift  <= bin_in;
                        r_digits <= '0;
                        r_cnt    <= CNT_W'(N_BITS);
                        r_ready  <= 1'b0;
                        r_state  <= OP;
                    end
                end
                OP: begin
                    r_digits <= w_next;
                    r_shift  <= {r_shift[N_BITS-2:0], 1'b0};
                    r_cnt    <= r_cnt - CNT_W'(1);
                    // The edge that performs the last shift also raises done.
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign done  = r_done;
endmodule
